// File: rtl/mem_arbiter.sv
// Shared-bus arbiter between instruction fetch and data access. Data normally wins;
// fetch is forced through after MAX_SKIP consecutive losses. Stuck bus accesses time out.
module mem_arbiter #(
    parameter logic [7:0]  TIMEOUT  = 8'd64,
    parameter int unsigned MAX_SKIP = 2
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_m_req,
    input  logic        i_m_we,
    input  logic [1:0]  i_m_size,
    input  logic [31:0] i_m_addr,
    input  logic [31:0] i_m_wdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [1:0]  o_bus_size,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    output logic        o_m_valid,
    output logic [31:0] o_m_rdata,
    output logic        o_err,
    output logic        o_if_stall,
    output logic        o_m_stall,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [1:0] SKIP_MAX  = MAX_SKIP[1:0];
    localparam logic [7:0] WAIT_LAST = TIMEOUT - 8'd1;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  skip_cnt;
    logic [7:0]  wait_cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic busy;
    logic grant;
    logic fetch_win;
    logic timeout;
    logic done;

    // Bus handshake: o_bus_req is held with stable address/data for the whole access;
    // the access ends in the cycle i_bus_ready=1 (or on timeout). Requesters hold
    // their req until their valid pulse, which is combinational in that same cycle.
    assign busy      = (state != IDLE);
    assign grant     = (state == IDLE) && (i_if_req || i_m_req);
    assign fetch_win = i_if_req && (!i_m_req || (skip_cnt == SKIP_MAX));
    assign timeout   = busy && !i_bus_ready && (wait_cnt == WAIT_LAST);
    assign done      = busy && (i_bus_ready || timeout);

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (grant) state_nxt = fetch_win ? FETCH : DATA;
            FETCH, DATA: if (done) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            skip_cnt <= 2'd0;
            wait_cnt <= 8'd0;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
        end else if (grant) begin
            wait_cnt <= 8'd0;
            if (fetch_win) begin
                skip_cnt <= 2'd0;
                we_q     <= 1'b0;
                size_q   <= 2'd2;
                addr_q   <= i_if_addr;
                wdata_q  <= 32'd0;
            end else begin
                // Only a loss that actually delayed a waiting fetch counts toward the skip limit.
                if (i_if_req && (skip_cnt < SKIP_MAX)) begin
                    skip_cnt <= skip_cnt + 2'd1;
                end
                we_q    <= i_m_we;
                size_q  <= i_m_size;
                addr_q  <= i_m_addr;
                wdata_q <= i_m_wdata;
            end
        end else if (busy && !i_bus_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        o_bus_req   = 1'b0;
        o_bus_we    = 1'b0;
        o_bus_size  = 2'd0;
        o_bus_addr  = 32'd0;
        o_bus_wdata = 32'd0;
        o_if_valid  = 1'b0;
        o_if_rdata  = 32'd0;
        o_m_valid   = 1'b0;
        o_m_rdata   = 32'd0;
        o_err       = 1'b0;
        case (state)
            FETCH: begin
                o_bus_req   = 1'b1;
                o_bus_we    = we_q;
                o_bus_size  = size_q;
                o_bus_addr  = addr_q;
                o_bus_wdata = wdata_q;
                o_if_valid  = done;
                o_if_rdata  = i_bus_ready ? i_bus_rdata : 32'd0;
                o_err       = timeout;
            end
            DATA: begin
                o_bus_req   = 1'b1;
                o_bus_we    = we_q;
                o_bus_size  = size_q;
                o_bus_addr  = addr_q;
                o_bus_wdata = wdata_q;
                o_m_valid   = done;
                o_m_rdata   = i_bus_ready ? i_bus_rdata : 32'd0;
                o_err       = timeout;
            end
            default: ;
        endcase
    end

    assign o_if_stall  = i_if_req & ~o_if_valid;
    assign o_m_stall   = i_m_req & ~o_m_valid;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: bus responder model, request drivers,
// grant/completion scoreboards and per-cycle output invariants.
module tb_mem_arbiter;

    localparam logic [7:0] TIMEOUT = 8'd64;

    logic        clk = 1'b0;
    logic        reset_x = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = 32'd0;
    logic        i_m_req = 1'b0;
    logic        i_m_we = 1'b0;
    logic [1:0]  i_m_size = 2'd0;
    logic [31:0] i_m_addr = 32'd0;
    logic [31:0] i_m_wdata = 32'd0;
    logic        i_bus_ready = 1'b0;
    logic [31:0] i_bus_rdata = 32'd0;
    logic        o_bus_req, o_bus_we;
    logic [1:0]  o_bus_size;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic        o_if_valid, o_m_valid, o_err, o_if_stall, o_m_stall;
    logic [31:0] o_if_rdata, o_m_rdata;
    logic [1:0]  o_dbg_state;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .MAX_SKIP(2)) dut (
        .clk(clk), .reset_x(reset_x),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .i_m_req(i_m_req), .i_m_we(i_m_we), .i_m_size(i_m_size),
        .i_m_addr(i_m_addr), .i_m_wdata(i_m_wdata),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_size(o_bus_size),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
        .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
        .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
        .o_m_valid(o_m_valid), .o_m_rdata(o_m_rdata),
        .o_err(o_err), .o_if_stall(o_if_stall), .o_m_stall(o_m_stall),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    // grant entry: {state, we, size, addr, wdata}; done entry: {m_valid, if_valid, err, rdata, bus cycles}
    logic [68:0] gnt_q[$];
    logic [42:0] done_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bus_model(input logic [31:0] a);
        if (a == 32'h0001_0000) return 32'h0000_0013;
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic void push_gnt(input logic [1:0] st, input logic we, input logic [1:0] sz,
                                     input logic [31:0] a, input logic [31:0] wd);
        gnt_q.push_back({st, we, sz, a, wd});
    endfunction

    function automatic void push_done(input logic is_data, input logic [31:0] a, input int rdy);
        if (rdy == 0 || rdy > int'(TIMEOUT))
            done_q.push_back({is_data, ~is_data, 1'b1, 32'd0, TIMEOUT});
        else
            done_q.push_back({is_data, ~is_data, 1'b0, bus_model(a), 8'(rdy)});
    endfunction

    // Bus responder: ready on bus cycle ready_at (0 = never); random noise while idle.
    int ready_at = 1;
    int bus_cyc = 0;
    always @(posedge clk) begin
        #1;
        bus_cyc = o_bus_req ? bus_cyc + 1 : 0;
        if (o_bus_req) begin
            i_bus_ready = (ready_at != 0) && (bus_cyc == ready_at);
            i_bus_rdata = i_bus_ready ? bus_model(o_bus_addr) : $urandom;
        end else begin
            i_bus_ready = 1'($urandom_range(0, 1));
            i_bus_rdata = $urandom;
        end
    end

    // Monitor: grants, completions and invariants, sampled mid-cycle.
    logic        prev_req = 1'b0;
    logic        idle_next = 1'b0;
    int          run_cyc = 0;
    logic [68:0] ge;
    logic [42:0] de;
    always @(negedge clk) begin
        run_cyc = o_bus_req ? (prev_req ? run_cyc + 1 : 1) : 0;
        if (idle_next) check("idle_after_done", 72'(o_bus_req), 72'(0));
        idle_next = o_if_valid | o_m_valid;
        if (o_bus_req && !prev_req) begin
            if (gnt_q.size() == 0) begin
                check("gnt_unexpected", 72'(o_dbg_state), 72'(0));
            end else begin
                ge = gnt_q.pop_front();
                check("grant", 72'({o_dbg_state, o_bus_we, o_bus_size, o_bus_addr,
                                    (ge[68:67] == 2'd1) ? 32'd0 : o_bus_wdata}), 72'(ge));
            end
        end
        if (o_if_valid || o_m_valid) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 72'({o_m_valid, o_if_valid}), 72'(0));
            end else begin
                de = done_q.pop_front();
                check("done", 72'({o_m_valid, o_if_valid, o_err,
                                   o_m_valid ? o_m_rdata : o_if_rdata, 8'(run_cyc)}), 72'(de));
            end
        end
        if (!o_bus_req)
            check("idle_bus_zero", 72'({o_bus_we, o_bus_size, o_bus_addr, o_bus_wdata}), 72'(0));
        if (!o_if_valid) check("if_rdata_zero", 72'(o_if_rdata), 72'(0));
        if (!o_m_valid) check("m_rdata_zero", 72'(o_m_rdata), 72'(0));
        check("stalls", 72'({o_if_stall, o_m_stall}),
              72'({i_if_req & ~o_if_valid, i_m_req & ~o_m_valid}));
        check("err_needs_valid", 72'(o_err & ~(o_if_valid | o_m_valid)), 72'(0));
        prev_req = o_bus_req;
    end

    task automatic fetch_req(input logic [31:0] addr);
        bit seen = 0;
        i_if_addr = addr;
        i_if_req  = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_if_valid) begin
                seen = 1;
                check("if_stall_at_valid", 72'(o_if_stall), 72'(0));
                break;
            end
        end
        if (!seen) check("fetch_wait_timeout", 72'(0), 72'(1));
        #2;
        i_if_req  = 1'b0;
        i_if_addr = $urandom;
    endtask

    task automatic data_req(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd);
        bit seen = 0;
        i_m_we    = we;
        i_m_size  = sz;
        i_m_addr  = addr;
        i_m_wdata = wd;
        i_m_req   = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_m_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("data_wait_timeout", 72'(0), 72'(1));
        #2;
        i_m_req   = 1'b0;
        i_m_addr  = $urandom;
        i_m_wdata = $urandom;
    endtask

    int          kind;
    logic [31:0] fa, ma, wd;
    logic        we;
    logic [1:0]  sz;
    bit          seen_req;

    initial begin
        #3000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state: bus idle, stall still follows the request.
        i_if_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs", 72'({o_bus_req, o_if_valid, o_m_valid, o_err, o_dbg_state}), 72'(0));
        check("rst_stall", 72'(o_if_stall), 72'(1));
        #2;
        i_if_req = 1'b0;
        reset_x  = 1'b1;
        @(negedge clk); #2;

        // Single fetch, ready on third bus cycle.
        ready_at = 3;
        push_gnt(2'd1, 1'b0, 2'd2, 32'h0001_0000, 32'd0);
        push_done(1'b0, 32'h0001_0000, 3);
        fetch_req(32'h0001_0000);

        // Fetch held against three back-to-back data requests: DATA, DATA, FETCH, DATA.
        ready_at = 2;
        push_gnt(2'd2, 1'b0, 2'd2, 32'h0000_3000, 32'd0);
        push_gnt(2'd2, 1'b1, 2'd1, 32'h0000_3004, 32'h0000_1234);
        push_gnt(2'd1, 1'b0, 2'd2, 32'h0000_0400, 32'd0);
        push_gnt(2'd2, 1'b0, 2'd0, 32'h0000_3009, 32'd0);
        push_done(1'b1, 32'h0000_3000, 2);
        push_done(1'b1, 32'h0000_3004, 2);
        push_done(1'b0, 32'h0000_0400, 2);
        push_done(1'b1, 32'h0000_3009, 2);
        fork
            fetch_req(32'h0000_0400);
            begin
                data_req(1'b0, 2'd2, 32'h0000_3000, 32'd0);
                data_req(1'b1, 2'd1, 32'h0000_3004, 32'h0000_1234);
                data_req(1'b0, 2'd0, 32'h0000_3009, 32'd0);
            end
        join

        // Simultaneous store and fetch with a cleared skip counter: data first.
        ready_at = 1;
        push_gnt(2'd2, 1'b1, 2'd2, 32'h0000_2000, 32'hdead_beef);
        push_gnt(2'd1, 1'b0, 2'd2, 32'h0001_0004, 32'd0);
        push_done(1'b1, 32'h0000_2000, 1);
        push_done(1'b0, 32'h0001_0004, 1);
        fork
            fetch_req(32'h0001_0004);
            data_req(1'b1, 2'd2, 32'h0000_2000, 32'hdead_beef);
        join

        // Random singles and pairs; a pair always starts with skip=0, so data wins.
        for (int it = 0; it < 12; it++) begin
            kind     = $urandom_range(0, 2);
            ready_at = $urandom_range(1, 5);
            fa = $urandom & 32'hffff_fffc;
            ma = $urandom;
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            if (kind != 0) begin
                push_gnt(2'd2, we, sz, ma, wd);
                push_done(1'b1, ma, ready_at);
            end
            if (kind != 1) begin
                push_gnt(2'd1, 1'b0, 2'd2, fa, 32'd0);
                push_done(1'b0, fa, ready_at);
            end
            case (kind)
                0: fetch_req(fa);
                1: data_req(we, sz, ma, wd);
                default: fork
                    fetch_req(fa);
                    data_req(we, sz, ma, wd);
                join
            endcase
        end

        // Ready coinciding with the last wait cycle: normal completion, no error.
        ready_at = int'(TIMEOUT);
        push_gnt(2'd2, 1'b0, 2'd2, 32'h0000_4000, 32'd0);
        push_done(1'b1, 32'h0000_4000, int'(TIMEOUT));
        data_req(1'b0, 2'd2, 32'h0000_4000, 32'd0);

        // Ready never comes: error completion on bus cycle TIMEOUT.
        ready_at = 0;
        push_gnt(2'd2, 1'b0, 2'd2, 32'h0000_5000, 32'd0);
        push_done(1'b1, 32'h0000_5000, 0);
        data_req(1'b0, 2'd2, 32'h0000_5000, 32'd0);

        // Reset in the second DATA cycle, request re-arbitrated afterwards.
        ready_at = 0;
        push_gnt(2'd2, 1'b0, 2'd2, 32'h0000_6000, 32'd0);
        push_gnt(2'd2, 1'b0, 2'd2, 32'h0000_6000, 32'd0);
        push_done(1'b1, 32'h0000_6000, 2);
        fork
            data_req(1'b0, 2'd2, 32'h0000_6000, 32'd0);
            begin
                seen_req = 0;
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (o_bus_req) begin
                        seen_req = 1;
                        break;
                    end
                end
                if (!seen_req) check("rst_test_no_grant", 72'(0), 72'(1));
                @(negedge clk);
                #2;
                reset_x = 1'b0;
                #1;
                check("rst_mid_access", 72'({o_bus_req, o_dbg_state, o_m_valid}), 72'(0));
                check("rst_mid_stall", 72'(o_m_stall), 72'(1));
                ready_at = 2;
                @(negedge clk);
                #2;
                reset_x = 1'b1;
            end
        join

        repeat (4) @(negedge clk);
        check("gnt_q_empty", 72'(gnt_q.size()), 72'(0));
        check("done_q_empty", 72'(done_q.size()), 72'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8'd64: the maximum number of cycles a granted bus access may wait for i_bus_ready.
REQ-002 The block SHALL have parameter MAX_SKIP, default 2: the number of consecutive arbitration losses by fetch before fetch is forced to win.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low; ports clk and reset_x.
REQ-004 The ports SHALL be:
- clk  in  1  clock
- reset_x  in  1  async reset, active low
- i_if_req  in  1  fetch request, held until o_if_valid
- i_if_addr  in  32  fetch address (PC)
- i_m_req  in  1  data request, held until o_m_valid
- i_m_we  in  1  data write
- i_m_size  in  2  0=byte, 1=half, 2=word
- i_m_addr  in  32  data address
- i_m_wdata  in  32  store data
- o_bus_req  out  1  bus access active
- o_bus_we  out  1  bus write
- o_bus_size  out  2  bus access size
- o_bus_addr  out  32  bus address
- o_bus_wdata  out  32  bus write data
- i_bus_ready  in  1  bus completes the access this cycle
- i_bus_rdata  in  32  bus read data
- o_if_valid / o_m_valid  out  1  access completion
- o_if_rdata / o_m_rdata  out  32  read data
- o_err  out  1  timeout completion
- o_if_stall / o_m_stall  out  1  stall requests to the hazard unit

Function
REQ-005 The FSM SHALL have three states, IDLE, FETCH and DATA; the state SHALL be registered.
REQ-006 In IDLE with any request pending, the block SHALL perform arbitration: data wins, except when the skip counter equals MAX_SKIP and i_if_req is high, in which case fetch wins.
REQ-007 On a grant, the block SHALL capture the winner's address (plus we, size and wdata for data; fetch forces we=0, size=2) into registers and enter FETCH or DATA at the next edge.
REQ-008 In FETCH and DATA, o_bus_req SHALL be 1 and the o_bus_* outputs SHALL drive the captured registers; in IDLE, every o_bus_* output SHALL be 0.
REQ-009 Completion occurs in the cycle where i_bus_ready=1 while in FETCH/DATA; in that cycle o_if_valid (FETCH) or o_m_valid (DATA) SHALL be 1 combinationally and the matching rdata SHALL equal i_bus_rdata; the FSM SHALL return to IDLE at the next edge.
REQ-010 The minimum latency from request to valid SHALL be 2 cycles (grant edge, then ready in the first bus cycle); no new grant is issued in the completion cycle.
REQ-011 When valid is 0, o_if_rdata and o_m_rdata SHALL be 0.
REQ-012 i_bus_ready in IDLE SHALL be ignored.
REQ-013 The skip counter (2 bits, saturating at MAX_SKIP) SHALL increment on each data grant made while i_if_req=1, and clear on every fetch grant.
REQ-014 The wait counter (8 bits) SHALL clear on grant and increment each FETCH/DATA cycle without ready.
REQ-015 When the wait counter reaches TIMEOUT-1 without ready, the access SHALL complete that cycle with valid=1, rdata=0 and o_err=1, and return to IDLE; o_err is 0 at all other times.
REQ-016 If ready and timeout coincide, ready SHALL take precedence: normal data and o_err=0.
REQ-017 The stalls SHALL be combinational: o_if_stall = i_if_req & ~o_if_valid, and o_m_stall = i_m_req & ~o_m_valid.
REQ-018 A request dropped while in FETCH/DATA SHALL NOT abort the access; the access completes and its valid pulse is ignored.

Reset
REQ-019 While reset_x=0, asynchronously, the state SHALL be IDLE, all counters and captured registers SHALL be 0, and all outputs SHALL be 0 except the combinational stalls.
REQ-020 Reset asserted mid-access SHALL drop o_bus_req immediately; after release, the request SHALL be re-arbitrated from IDLE.

Verification
REQ-021 Fetch only, addr 32'h10000, ready on the 3rd bus cycle, rdata 32'h00000013 -> o_bus_req high for 3 cycles, o_if_valid for 1 cycle with 32'h13, o_if_stall low in that cycle.
REQ-022 i_if_req and i_m_req both asserted at the same time, with a store of 32'hDEADBEEF to 32'h2000 at size 2 -> the DATA grant comes first with o_bus_we=1 and o_bus_wdata=32'hDEADBEEF; fetch is granted after o_m_valid.
REQ-023 Fetch held while data is requested back-to-back 3 times -> the sequence of grants is DATA, DATA, FETCH; the skip counter clears after FETCH.
REQ-024 Data load with i_bus_ready held at 0 -> at bus cycle 64, o_m_valid=1, o_err=1 and o_m_rdata=0, then IDLE.
REQ-025 reset_x pulsed low in the second cycle of DATA -> o_bus_req drops without waiting for clk; after release with i_m_req still high, a fresh DATA grant occurs.
